// File: rtl/psum_ofifo.sv
// psum_ofifo: output-side collector for the mac_array psum stream.
//
// Each MAC column owns a private FIFO fed by its own write strobe, so columns
// may arrive skewed in time. Once every column holds at least one entry, a
// full row (one psum per column) is presented first-word-fall-through, and a
// row pop advances all columns together.
//
// Parameters:
//   col      number of MAC columns / psum lanes
//   bw_psum  psum width in bits (passed through unmodified)
//   depth    entries per column FIFO (power of two, >= 2)
//
// Ports:
//   clk      clock, rising edge
//   reset    synchronous active-high reset (pointers and overflow flag only)
//   in       psum lanes, lane i = in[bw_psum*(i+1)-1 : bw_psum*i]
//   wr       per-column write strobes, wr[i] writes lane i
//   rd       row pop request (ignored while o_valid is low)
//   out      head row, all zeros while o_valid is low
//   o_valid  every column FIFO non-empty
//   o_full   any column FIFO holds depth entries
//   o_ready  no column FIFO full
//   ovf      sticky dropped-write flag, present only with PSUM_OFIFO_OVF_EN
//
// Optional feature macro: PSUM_OFIFO_OVF_EN
module psum_ofifo #(
    parameter int col     = 8,
    parameter int bw_psum = 22,
    parameter int depth   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*bw_psum-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*bw_psum-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready
`ifdef PSUM_OFIFO_OVF_EN
    ,
    output logic                   ovf
`endif
);

    localparam int AW = $clog2(depth);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_CNT = PW'(depth);

    logic [bw_psum-1:0] mem_q [col][depth];
    logic [PW-1:0]      wptr_q [col];
    logic [PW-1:0]      wptr_d [col];
    logic [PW-1:0]      rptr_q;
    logic [PW-1:0]      rptr_d;
    logic [PW-1:0]      count [col];
    logic [col-1:0]     nonempty;
    logic [col-1:0]     full;
    logic [col-1:0]     wr_ok;
    logic               pop;

    // All columns pop in lockstep, so a single shared read pointer suffices.
    always_comb begin
        nonempty = '0;
        full     = '0;
        for (int i = 0; i < col; i++) begin
            count[i]    = wptr_q[i] - rptr_q;
            nonempty[i] = (count[i] != '0);
            full[i]     = (count[i] == DEPTH_CNT);
        end
    end

    assign o_valid = &nonempty;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    // A full column still accepts a write when the head is popped in the same
    // cycle: the write slot is the one being vacated.
    always_comb begin
        wr_ok = '0;
        for (int i = 0; i < col; i++) begin
            wr_ok[i]  = wr[i] & (~full[i] | pop);
            wptr_d[i] = wptr_q[i] + PW'(wr_ok[i]);
        end
        rptr_d = rptr_q + PW'(pop);
    end

    always_comb begin
        out = '0;
        if (o_valid) begin
            for (int i = 0; i < col; i++) begin
                out[i*bw_psum +: bw_psum] = mem_q[i][rptr_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < col; i++) begin
                wptr_q[i] <= '0;
            end
            rptr_q <= '0;
        end else begin
            for (int i = 0; i < col; i++) begin
                wptr_q[i] <= wptr_d[i];
            end
            rptr_q <= rptr_d;
        end
    end

    // Storage is never cleared; writes during reset are suppressed so the
    // reset cycle has no side effects on later reads.
    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (wr_ok[i] && !reset) begin
                mem_q[i][wptr_q[i][AW-1:0]] <= in[i*bw_psum +: bw_psum];
            end
        end
    end

`ifdef PSUM_OFIFO_OVF_EN
    logic ovf_q;
    logic any_drop;

    assign any_drop = |(wr & full & ~{col{pop}});

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (any_drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_psum_ofifo.sv
// tb_psum_ofifo: directed bench for psum_ofifo with a row scoreboard.
// Expected rows are queued when written and compared when popped.
module tb_psum_ofifo;

    localparam int COL  = 8;
    localparam int BW   = 22;
    localparam int ROWW = COL * BW;

    logic            clk;
    logic            reset;
    logic [ROWW-1:0] in;
    logic [COL-1:0]  wr;
    logic            rd;
    logic [ROWW-1:0] out;
    logic            o_valid;
    logic            o_full;
    logic            o_ready;
`ifdef PSUM_OFIFO_OVF_EN
    logic            ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic [ROWW-1:0] sb [$];

    psum_ofifo #(.col(COL), .bw_psum(BW), .depth(16)) dut (
`ifdef PSUM_OFIFO_OVF_EN
        .ovf     (ovf),
`endif
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .wr      (wr),
        .rd      (rd),
        .out     (out),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ROWW-1:0] row_of(input logic [BW-1:0] v);
        logic [ROWW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic write_row(input logic [BW-1:0] v);
        wr = '1;
        in = row_of(v);
        tick();
        wr = '0;
        sb.push_back(row_of(v));
    endtask

    // Compare the head row against the scoreboard, then pop it, optionally
    // writing a new row of value v in the same cycle.
    task automatic pop_row(input bit do_wr, input logic [BW-1:0] v);
        logic [ROWW-1:0] e;
        chk("valid_before_pop", {255'd0, o_valid}, 256'd1);
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_empty: observed %0d entries expected >0", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("pop_row", {80'd0, out}, {80'd0, e});
        end
        rd = 1'b1;
        if (do_wr) begin
            wr = '1;
            in = row_of(v);
        end
        tick();
        rd = 1'b0;
        wr = '0;
        if (do_wr) sb.push_back(row_of(v));
    endtask

    initial begin
        logic [ROWW-1:0] row;
        reset = 1'b0;
        in    = '0;
        wr    = '0;
        rd    = 1'b0;
        do_reset();

        // Reset state
        chk("rst_valid", {255'd0, o_valid}, 256'd0);
        chk("rst_full",  {255'd0, o_full},  256'd0);
        chk("rst_ready", {255'd0, o_ready}, 256'd1);
        chk("rst_out",   {80'd0, out},      256'd0);
`ifdef PSUM_OFIFO_OVF_EN
        chk("rst_ovf",   {255'd0, ovf},     256'd0);
`endif

        // 1. Skewed fill
        for (int i = 0; i < COL; i++) row[i*BW +: BW] = BW'(100 + i);
        in = row;
        for (int i = 0; i < COL; i++) begin
            chk("skew_valid_low", {255'd0, o_valid}, 256'd0);
            wr = COL'(1) << i;
            tick();
        end
        wr = '0;
        sb.push_back(row);
        chk("skew_valid_high", {255'd0, o_valid}, 256'd1);
        pop_row(1'b0, '0);
        chk("skew_valid_after_pop", {255'd0, o_valid}, 256'd0);

        // 2. Signed passthrough
        row = '0;
        row[0 +: BW]     = 22'h3FFFFB;
        row[7*BW +: BW]  = 22'h1FFFFF;
        in = row;
        wr = '1;
        tick();
        wr = '0;
        sb.push_back(row);
        chk("signed_lane0", {234'd0, out[0 +: BW]},    {234'd0, 22'h3FFFFB});
        chk("signed_lane7", {234'd0, out[7*BW +: BW]}, {234'd0, 22'h1FFFFF});
        pop_row(1'b0, '0);
        chk("signed_empty", {255'd0, o_valid}, 256'd0);

        // 3. Full and drop
        for (int r = 0; r < 16; r++) begin
            chk("fill_not_full", {255'd0, o_full}, 256'd0);
            write_row(BW'(r));
        end
        chk("full_set",    {255'd0, o_full},  256'd1);
        chk("ready_clear", {255'd0, o_ready}, 256'd0);
        wr = '1;
        in = row_of(22'd99);
        tick();
        wr = '0;
        chk("drop_full_held", {255'd0, o_full}, 256'd1);
`ifdef PSUM_OFIFO_OVF_EN
        chk("drop_ovf", {255'd0, ovf}, 256'd1);
`endif
        for (int r = 0; r < 16; r++) pop_row(1'b0, '0);
        chk("drain_empty", {255'd0, o_valid}, 256'd0);
        chk("drain_ready", {255'd0, o_ready}, 256'd1);

        // 4. Concurrent read/write at full
        do_reset();
        for (int r = 0; r < 16; r++) write_row(BW'(r));
        chk("rw_full_before", {255'd0, o_full}, 256'd1);
        pop_row(1'b1, 22'd200);
        chk("rw_full_after", {255'd0, o_full}, 256'd1);
`ifdef PSUM_OFIFO_OVF_EN
        chk("rw_no_ovf", {255'd0, ovf}, 256'd0);
`endif
        for (int r = 0; r < 16; r++) pop_row(1'b0, '0);
        chk("rw_drain_empty", {255'd0, o_valid}, 256'd0);

        // 5. Pointer wrap, one row in flight
        write_row(22'd0);
        for (int k = 0; k < 40; k++) begin
            chk("wrap_not_full", {255'd0, o_full}, 256'd0);
            pop_row(k < 39, BW'(k + 1));
        end
        chk("wrap_empty", {255'd0, o_valid}, 256'd0);

        // 6. Reset mid-stream
        for (int r = 0; r < 5; r++) write_row(BW'(10 + r));
        reset = 1'b1;
        wr    = '1;
        rd    = 1'b1;
        in    = row_of(22'd55);
        tick();
        reset = 1'b0;
        wr    = '0;
        rd    = 1'b0;
        sb.delete();
        chk("mid_rst_valid", {255'd0, o_valid}, 256'd0);
        chk("mid_rst_full",  {255'd0, o_full},  256'd0);
        chk("mid_rst_out",   {80'd0, out},      256'd0);
`ifdef PSUM_OFIFO_OVF_EN
        chk("mid_rst_ovf",   {255'd0, ovf},     256'd0);
`endif
        write_row(22'd7);
        pop_row(1'b0, '0);
        chk("post_rst_empty", {255'd0, o_valid}, 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psum_ofifo.md
Name: psum_ofifo

Overview:
- Output-side collector for the mac_array psum stream.
- Each column's psum and its per-column `fifo_wr` strobe land in a private per-column FIFO. Columns arrive skewed in time.
- A full row, with one psum from every column, is presented to the downstream reader / SFU stage once all columns hold at least one entry.
- Row reads are first-word-fall-through and pop all columns at once.

Parameters:
- col, 8, number of MAC columns / psum lanes
- bw_psum, 22, psum width in bits (two's complement, passed through unmodified)
- depth, 16, entries per column FIFO; must be a power of two, ≥2

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in  input  col*bw_psum  psum lanes; lane i = in[bw_psum*(i+1)-1 : bw_psum*i]
- wr  input  col  per-column write strobe (mac_array fifo_wr); wr[i] writes lane i
- rd  input  1  row pop request
- out  output  col*bw_psum  head row; lane i = head of column i FIFO
- o_valid  output  1  every column FIFO non-empty
- o_full  output  1  any column FIFO holds depth entries
- o_ready  output  1  no column FIFO full (= ~o_full)

Behaviour:
- Storage and pointers:
  - Per column: depth x bw_psum storage array.
  - Write pointer and read pointer, each log2(depth)+1 bits.
  - count = wptr - rptr (modulo arithmetic). The extra MSB distinguishes full from empty.
  - Pointers wrap naturally modulo 2*depth; the storage index is the low log2(depth) bits.
- Reset (synchronous, reset=1 at the edge):
  - All pointers go to 0.
  - o_valid=0, o_full=0, o_ready=1, out=0.
  - Storage contents are not cleared.
  - Reset mid-stream discards all buffered data. Writes and reads presented in the reset cycle are ignored.
- Write, column i:
  - If wr[i]=1 and (count_i < depth, or a pop of this row occurs in the same cycle), store in lane i at wptr_i and increment wptr_i.
  - Otherwise the write is dropped and the pointers are unchanged.
  - Columns are fully independent; any subset of wr bits may be set in a cycle.
- Read:
  - A pop occurs when rd=1 and o_valid=1. It increments every column's rptr by 1.
  - rd=1 with o_valid=0 is ignored. No pointer moves and there is no error.
- Output, combinational from the registered state:
  - o_valid = AND over columns of (count_i != 0).
  - o_full = OR over columns of (count_i == depth).
  - out = head entries when o_valid=1, otherwise all zeros.
  - Latency: a write to the last-empty column makes o_valid rise on the cycle after the write edge. A popped row disappears the cycle after the pop edge.
- Simultaneous read and write:
  - Write to an empty column in the same cycle as a rd: no pop, because o_valid=0. The data becomes visible next cycle.
  - Write plus pop on a full column: both proceed, and count stays at depth.
  - Write plus pop on a partially filled column: count is unchanged.
- Ordering: each column is strictly FIFO, and row k of out pairs the k-th write of each column.

Optional Feature:
- Macro: PSUM_OFIFO_OVF_EN.
- Defined:
  - Extra output port `ovf` (1 bit) is present.
  - `ovf` is sticky. It is set on the cycle after any dropped write (wr[i]=1, count_i==depth, no concurrent pop).
  - It is cleared only by reset.
- Not defined: port `ovf` is absent. Dropped writes are silent; the data-path behaviour is otherwise identical.

Test Plan:
1. Skewed fill, col=8: pulse wr[i] at cycle t0+i with lane i = 100+i. Then:
   - o_valid=0 through cycle t0+7.
   - o_valid=1 at t0+8, with out lanes = 100..107.
   - rd=1 for one cycle, then o_valid=0.
2. Signed passthrough: write lane 0 = -5 (0x3FFFFB) and lane 7 = 0x1FFFFF, fill the other lanes with 0, pop. Required: out lane 0 = 0x3FFFFB and lane 7 = 0x1FFFFF, bit-exact.
3. Full and drop:
   - Write 16 rows of value r (r=0..15) on all columns without reading. o_full=1 and o_ready=0 after the 16th.
   - A 17th write (value 99) is dropped, and `ovf`=1 when PSUM_OFIFO_OVF_EN is defined.
   - 16 pops return 0..15 in order, then o_valid=0.
4. Concurrent read/write at full: with all columns full, assert rd=1 and wr=all ones with value 200 in the same cycle.
   - o_full stays 1 and `ovf` stays 0.
   - Draining returns 1..15, then 200.
5. Pointer wrap: run 40 rows of continuous write-then-pop, 1 row in flight, values 0..39. Every popped value matches its sequence, and o_full never asserts.
6. Reset mid-stream:
   - Buffer 5 rows, then assert reset for 1 cycle with wr=all ones and rd=1. Then o_valid=0, o_full=0, out=0, and `ovf`=0.
   - A following single-row write of 7 on all columns is the next row read out.
